// File: rtl/wb_mem_bist_if.sv
// Wishbone master-side bus bundle between the BIST engine and the SRAM slave port.
interface wb_mem_bist_if;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/wb_mem_bist.sv
// Wishbone master march BIST: write P, read P, write ~P, read ~P over MEM_WORDS words.
module wb_mem_bist #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start_i,
    input  logic [31:0]   seed_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic          timeout_o,
    output logic [15:0]   err_cnt_o,
    output logic [31:0]   fail_adr_o,
    output logic [31:0]   fail_dat_o,
    wb_mem_bist_if.master wbm
);
    localparam int unsigned IDX_W = 16;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, FIN} state_t;

    state_t           state;
    logic [31:0]      seed_q;
    logic [1:0]       phase;     // bit0: read phase, bit1: inverted pattern
    logic [IDX_W-1:0] idx;
    logic [TMO_W-1:0] tmo_cnt;

    logic             last_c;
    logic [IDX_W-1:0] nxt_idx_c;
    logic [1:0]       nxt_phase_c;
    logic [31:0]      nxt_adr_c;
    logic [31:0]      nxt_dat_c;
    logic [31:0]      exp_c;

    function automatic logic [31:0] pattern(input logic [31:0] s, input logic [IDX_W-1:0] i);
        return s ^ {i, ~i};
    endfunction

    // Next word/phase and the expected read value for the word on the bus
    always_comb begin
        last_c      = (idx == LAST_IDX);
        nxt_idx_c   = last_c ? '0 : idx + IDX_W'(1);
        nxt_phase_c = last_c ? phase + 2'd1 : phase;
        nxt_adr_c   = BASE_ADR + 32'({nxt_idx_c, 2'b00});
        nxt_dat_c   = nxt_phase_c[0] ? 32'h0 : (pattern(seed_q, nxt_idx_c) ^ {32{nxt_phase_c[1]}});
        exp_c       = pattern(seed_q, idx) ^ {32{phase[1]}};
    end

    // Sequencer: IDLE -> (ISSUE -> GAP)* -> FIN, all outputs registered
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            seed_q        <= '0;
            phase         <= '0;
            idx           <= '0;
            tmo_cnt       <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
            timeout_o     <= 1'b0;
            err_cnt_o     <= '0;
            fail_adr_o    <= '0;
            fail_dat_o    <= '0;
            wbm.wbm_adr_o <= '0;
            wbm.wbm_dat_o <= '0;
            wbm.wbm_sel_o <= '0;
            wbm.wbm_we_o  <= 1'b0;
            wbm.wbm_cyc_o <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        seed_q        <= seed_i;
                        phase         <= '0;
                        idx           <= '0;
                        tmo_cnt       <= '0;
                        busy_o        <= 1'b1;
                        pass_o        <= 1'b0;
                        timeout_o     <= 1'b0;
                        err_cnt_o     <= '0;
                        fail_adr_o    <= '0;
                        fail_dat_o    <= '0;
                        wbm.wbm_adr_o <= BASE_ADR;
                        wbm.wbm_dat_o <= pattern(seed_i, '0);
                        wbm.wbm_sel_o <= 4'hF;
                        wbm.wbm_we_o  <= 1'b1;
                        wbm.wbm_cyc_o <= 1'b1;
                        wbm.wbm_stb_o <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wbm.wbm_ack_i) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        wbm.wbm_sel_o <= '0;
                        wbm.wbm_we_o  <= 1'b0;
                        state         <= GAP;
                        if (phase[0] && (wbm.wbm_dat_i != exp_c)) begin
                            if (err_cnt_o != 16'hFFFF) begin
                                err_cnt_o <= err_cnt_o + 16'd1;
                            end
                            if (err_cnt_o == 16'd0) begin
                                fail_adr_o <= wbm.wbm_adr_o;
                                fail_dat_o <= wbm.wbm_dat_i;
                            end
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        wbm.wbm_sel_o <= '0;
                        wbm.wbm_we_o  <= 1'b0;
                        timeout_o     <= 1'b1;
                        done_o        <= 1'b1;
                        state         <= FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                GAP: begin
                    if (last_c && (phase == 2'd3)) begin
                        done_o <= 1'b1;
                        pass_o <= (err_cnt_o == 16'd0);
                        state  <= FIN;
                    end else begin
                        idx           <= nxt_idx_c;
                        phase         <= nxt_phase_c;
                        tmo_cnt       <= '0;
                        wbm.wbm_adr_o <= nxt_adr_c;
                        wbm.wbm_dat_o <= nxt_dat_c;
                        wbm.wbm_we_o  <= ~nxt_phase_c[0];
                        wbm.wbm_sel_o <= 4'hF;
                        wbm.wbm_cyc_o <= 1'b1;
                        wbm.wbm_stb_o <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                FIN: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
